// File: rtl/multi_btn_edge.sv
// multi_btn_edge: per-channel sync, debounce and edge-pulse generator.
// Optional held-button repeat pulses when BTN_REPEAT_EN is defined.
module multi_btn_edge #(
  parameter int CH            = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int DB_W          = 8,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_CYCLES = 1000,
  parameter int RPT_W         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CH-1:0] btn_raw,
  output logic [CH-1:0] btn_level,
  output logic [CH-1:0] pulse,
  output logic          any_pulse
);

  if (DB_CYCLES < 1 || DB_CYCLES > 2**DB_W - 1 ||
      EDGE_MODE < 0 || EDGE_MODE > 2 ||
      REPEAT_CYCLES < 1 ||
      REPEAT_CYCLES > 2**RPT_W - 1) begin : g_bad_cfg
    $error("multi_btn_edge: illegal parameters");
  end

  localparam logic [DB_W-1:0] DB_MAX =
    DB_W'(DB_CYCLES - 1);

  logic [CH-1:0]   sync_q [SYNC_STAGES];
  logic [CH-1:0]   sync_out;
  logic [CH-1:0]   lvl;
  logic [CH-1:0]   lvl_d;
  logic [CH-1:0]   rise;
  logic [CH-1:0]   fall;
  logic [CH-1:0]   rpt;
  logic [CH-1:0]   sel;
  logic [DB_W-1:0] db_cnt [CH];

  // Metastability chain, one flop per stage per channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= btn_raw;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Accept a new level only after it persists DB_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl   <= '0;
      lvl_d <= '0;
      for (int c = 0; c < CH; c++)
        db_cnt[c] <= '0;
    end else begin
      lvl_d <= lvl;
      for (int c = 0; c < CH; c++) begin
        if (sync_out[c] == lvl[c]) begin
          db_cnt[c] <= '0;
        end else if (db_cnt[c] == DB_MAX) begin
          lvl[c]    <= sync_out[c];
          db_cnt[c] <= '0;
        end else begin
          db_cnt[c] <= db_cnt[c] + 1'b1;
        end
      end
    end
  end

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

`ifdef BTN_REPEAT_EN
  if (EDGE_MODE != 1) begin : g_rpt
    localparam logic [RPT_W-1:0] RPT_MAX =
      RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt [CH];
    logic [CH-1:0]    rpt_q;

    // Count held cycles; flag one cycle per wrap
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt_q <= '0;
        for (int c = 0; c < CH; c++)
          rpt_cnt[c] <= '0;
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (!lvl[c]) begin
            rpt_cnt[c] <= '0;
            rpt_q[c]   <= 1'b0;
          end else if (rpt_cnt[c] == RPT_MAX) begin
            rpt_cnt[c] <= '0;
            rpt_q[c]   <= 1'b1;
          end else begin
            rpt_cnt[c] <= rpt_cnt[c] + 1'b1;
            rpt_q[c]   <= 1'b0;
          end
        end
      end
    end

    assign rpt = rpt_q & lvl;
  end else begin : g_no_rpt
    assign rpt = '0;
  end
`else
  assign rpt = '0;
`endif

  // Pick which edges produce a pulse
  always_comb begin
    sel = '0;
    unique case (1'b1)
      EDGE_MODE == 0: sel = rise | rpt;
      EDGE_MODE == 1: sel = fall;
      default:        sel = rise | fall | rpt;
    endcase
  end

  assign btn_level = lvl;
  assign pulse     = sel & {CH{en}};
  assign any_pulse = |pulse;

endmodule

// File: tb/tb_multi_btn_edge.sv
// tb_multi_btn_edge: vector table over three edge modes,
// plus reset and repeat sequences.
module tb_multi_btn_edge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [1:0] btn_raw = '0;

  logic [1:0] lvl0, lvl1, lvl2;
  logic [1:0] p0, p1, p2;
  logic       any0, any1, any2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multi_btn_edge #(.EDGE_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .btn_raw(btn_raw),
    .btn_level(lvl0), .pulse(p0), .any_pulse(any0)
  );

  multi_btn_edge #(.EDGE_MODE(1)) u_fall (
    .clk(clk), .rst(rst), .en(en), .btn_raw(btn_raw),
    .btn_level(lvl1), .pulse(p1), .any_pulse(any1)
  );

  multi_btn_edge #(.EDGE_MODE(2)) u_both (
    .clk(clk), .rst(rst), .en(en), .btn_raw(btn_raw),
    .btn_level(lvl2), .pulse(p2), .any_pulse(any2)
  );

`ifdef BTN_REPEAT_EN
  logic [1:0] lvl_r, p_r;
  logic       any_r;

  multi_btn_edge #(
    .EDGE_MODE(0), .REPEAT_CYCLES(10)
  ) u_rpt (
    .clk(clk), .rst(rst), .en(en), .btn_raw(btn_raw),
    .btn_level(lvl_r), .pulse(p_r), .any_pulse(any_r)
  );
`endif

  typedef struct {
    logic [1:0] raw;
    logic       en;
    logic [1:0] lvl;
    logic [1:0] e0;
    logic [1:0] e1;
    logic [1:0] e2;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input logic [1:0] raw,
                     input logic e, input logic [1:0] lv,
                     input logic [1:0] x0, input logic [1:0] x1,
                     input logic [1:0] x2);
    vec_t v;
    v.raw = raw; v.en = e; v.lvl = lv;
    v.e0 = x0; v.e1 = x1; v.e2 = x2;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h want %0h",
                  name, idx, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // glitch of 3 cycles rejected
    add(3,  2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(4,  2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // exactly 4 cycles accepted, then released
    add(4,  2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1,  2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1,  2'b00, 1, 2'b01, 2'b01, 2'b00, 2'b01);
    add(3,  2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1,  2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b01);
    add(2,  2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // 20-cycle press, then release
    add(5,  2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1,  2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b01);
    add(14, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(5,  2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1,  2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b01);
    add(3,  2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // press with en low, raise en while held
    add(5,  2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add(4,  2'b01, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    add(3,  2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    // release edge lands while en low: dropped
    add(5,  2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1,  2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2,  2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // both channels together
    add(5,  2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1,  2'b11, 1, 2'b11, 2'b11, 2'b00, 2'b11);
    add(2,  2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(5,  2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1,  2'b00, 1, 2'b00, 2'b00, 2'b11, 2'b11);
    add(2,  2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lvl", 0, lvl0, 2'b00);
    chk("rst_pulse", 0, p0, 2'b00);
    chk("rst_any", 0, any0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      btn_raw = vq[i].raw;
      en      = vq[i].en;
      step();
      chk("lvl_m0", i, lvl0, vq[i].lvl);
      chk("lvl_m1", i, lvl1, vq[i].lvl);
      chk("lvl_m2", i, lvl2, vq[i].lvl);
      chk("pulse_m0", i, p0, vq[i].e0);
      chk("pulse_m1", i, p1, vq[i].e1);
      chk("pulse_m2", i, p2, vq[i].e2);
      chk("any_m0", i, any0, |vq[i].e0);
      chk("any_m2", i, any2, |vq[i].e2);
    end

    // reset mid-operation with ch1 level high
    en = 1'b1;
    btn_raw = 2'b10;
    repeat (6) step();
    chk("pre_lvl", 0, lvl0, 2'b10);
    chk("pre_pulse", 0, p0, 2'b10);
    btn_raw = 2'b11;
    repeat (4) step();
    chk("pre_rst_lvl", 0, lvl0, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_lvl", 0, lvl0, 2'b00);
    chk("mid_rst_lvl2", 0, lvl2, 2'b00);
    chk("mid_rst_pulse", 0, p0, 2'b00);
    chk("mid_rst_any", 0, any0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("post_lvl", e, lvl0,
          (e >= 6) ? 2'b11 : 2'b00);
      chk("post_pulse", e, p0,
          (e == 6) ? 2'b11 : 2'b00);
      chk("post_any", e, any0, e == 6);
      chk("post_fall", e, p1, 2'b00);
    end

`ifdef BTN_REPEAT_EN
    btn_raw = 2'b00;
    repeat (10) step();
    btn_raw = 2'b01;
    repeat (6) step();
    chk("rpt_first", 0, p_r, 2'b01);
    for (int k = 1; k <= 33; k++) begin
      step();
      chk("rpt_hold", k, p_r,
          (k % 10 == 0) ? 2'b01 : 2'b00);
    end
    btn_raw = 2'b00;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("rpt_rel", k, p_r, 2'b00);
    end
    chk("rpt_lvl", 0, lvl_r, 2'b00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
